// File: rtl/reset_aggregator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reset_aggregator_if                                                        |
// | Monitor-request / system-reset bundle between the monitors and aggregator. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface reset_aggregator_if #(
   parameter int N_SRC = 3,
   parameter int CNT_W = 8
);
   logic [N_SRC-1:0] src_reset;
   logic             clear_cause;
   logic             sys_reset;
   logic [N_SRC-1:0] cause;
   logic [CNT_W-1:0] viol_cnt;

   // master: monitor/debug side; slave: the aggregator itself
   modport master (
      output src_reset, clear_cause,
      input  sys_reset, cause, viol_cnt
   );

   modport slave (
      input  src_reset, clear_cause,
      output sys_reset, cause, viol_cnt
   );
endinterface
`default_nettype wire

// File: rtl/reset_aggregator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reset_aggregator                                                           |
// | ORs monitor reset requests into a stretched system reset; logs first cause |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reset_aggregator #(
   parameter int N_SRC   = 3,
   parameter int STRETCH = 4,
   parameter int SW      = 8,
   parameter int CNT_W   = 8
) (
   input  wire logic          clk,
   input  wire logic          reset,
   reset_aggregator_if.slave  agg
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [SW-1:0]    C_HOLD_RELOAD = SW'(STRETCH - 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX     = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [SW-1:0]    hold_cnt_q, hold_cnt_d;
   logic [N_SRC-1:0] cause_q, cause_d;
   logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
   logic             w_any_req;

   assign w_any_req = |agg.src_reset;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      cause_d    = cause_q;
      viol_cnt_d = viol_cnt_q;
      case (state_q)
         RUN: begin
            if (w_any_req) begin
               state_d    = HOLD;
               hold_cnt_d = C_HOLD_RELOAD;
               if (viol_cnt_q != C_CNT_MAX) begin
                  viol_cnt_d = viol_cnt_q + CNT_W'(1);
               end
               // A simultaneous clear takes effect first, so the new request is captured.
               if ((cause_q == '0) || agg.clear_cause) begin
                  cause_d = agg.src_reset;
               end
            end else if (agg.clear_cause) begin
               cause_d = '0;
            end
         end
         HOLD: begin
            if (w_any_req) begin
               hold_cnt_d = C_HOLD_RELOAD;
            end else if (hold_cnt_q != '0) begin
               hold_cnt_d = hold_cnt_q - SW'(1);
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d    = HOLD;
            hold_cnt_d = C_HOLD_RELOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= HOLD;
         hold_cnt_q <= C_HOLD_RELOAD;
         cause_q    <= '0;
         viol_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         cause_q    <= cause_d;
         viol_cnt_q <= viol_cnt_d;
      end
   end

   // sys_reset comes straight off the state flop: no combinational path from src_reset.
   assign agg.sys_reset = (state_q == HOLD);
   assign agg.cause     = cause_q;
   assign agg.viol_cnt  = viol_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_aggregator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reset_aggregator                                                        |
// | Scoreboard bench: directed scenarios plus random requests, two counter sizes|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_reset_aggregator;

   localparam int N_SRC   = 3;
   localparam int STRETCH = 4;

   typedef struct {
      bit         sys;
      logic [2:0] cause;
      int         cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] src = '0;
   logic       clr = 1'b0;

   int checks = 0;
   int errors = 0;
   exp_t sb_q[$];

   // Reference model state: stretching is tracked as a run of clean cycles.
   bit         m_hold  = 1'b1;
   int         m_clean = 0;
   logic [2:0] m_cause = '0;
   int         m_cnt   = 0;

   reset_aggregator_if #(.N_SRC(N_SRC), .CNT_W(8)) bus8 ();
   reset_aggregator_if #(.N_SRC(N_SRC), .CNT_W(2)) bus2 ();

   assign bus8.src_reset   = src;
   assign bus8.clear_cause = clr;
   assign bus2.src_reset   = src;
   assign bus2.clear_cause = clr;

   reset_aggregator #(.N_SRC(N_SRC), .STRETCH(STRETCH), .SW(8), .CNT_W(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .agg   (bus8.slave)
   );

   reset_aggregator #(.N_SRC(N_SRC), .STRETCH(STRETCH), .SW(8), .CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .agg   (bus2.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs and push what every output must be after the edge.
   task automatic step(input bit r, input logic [2:0] s, input bit c);
      exp_t e;
      @(negedge clk);
      reset = r;
      src   = s;
      clr   = c;
      if (r) begin
         m_hold  = 1'b1;
         m_clean = 0;
         m_cause = '0;
         m_cnt   = 0;
      end else if (!m_hold) begin
         if (s != 0) begin
            m_hold  = 1'b1;
            m_clean = 0;
            m_cnt   = m_cnt + 1;
            if (m_cause == 0 || c) m_cause = s;
         end else if (c) begin
            m_cause = '0;
         end
      end else begin
         if (s != 0) begin
            m_clean = 0;
         end else begin
            m_clean = m_clean + 1;
            if (m_clean == STRETCH) m_hold = 1'b0;
         end
      end
      e.sys   = m_hold;
      e.cause = m_cause;
      e.cnt   = m_cnt;
      sb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0);
   endtask

   // Monitor: outputs are valid every cycle; compare once per edge against the oldest entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sys_reset",      int'(bus8.sys_reset), int'(e.sys));
            check("cause",          int'(bus8.cause),     int'(e.cause));
            check("viol_cnt",       int'(bus8.viol_cnt),  (e.cnt > 255) ? 255 : e.cnt);
            check("sys_reset_w2",   int'(bus2.sys_reset), int'(e.sys));
            check("cause_w2",       int'(bus2.cause),     int'(e.cause));
            check("viol_cnt_w2",    int'(bus2.viol_cnt),  (e.cnt > 3) ? 3 : e.cnt);
         end
      end
   end

   initial begin
      // Reset then exactly STRETCH cycles of sys_reset.
      step(1'b1, 3'b000, 1'b0);
      idle(6);
      // Single-cycle request, second request keeps first cause, then clear.
      step(1'b0, 3'b010, 1'b0);
      idle(6);
      step(1'b0, 3'b100, 1'b0);
      idle(6);
      step(1'b0, 3'b000, 1'b1);
      idle(2);
      // Long request counts once and releases STRETCH cycles after it drops.
      for (int i = 0; i < 10; i++) step(1'b0, 3'b001, 1'b0);
      idle(6);
      step(1'b0, 3'b000, 1'b1);
      // Violation with simultaneous clear replaces an existing cause.
      step(1'b0, 3'b100, 1'b0);
      idle(6);
      step(1'b0, 3'b011, 1'b1);
      idle(6);
      // Clear ignored while in HOLD.
      step(1'b0, 3'b001, 1'b0);
      step(1'b0, 3'b000, 1'b1);
      idle(6);
      // Separated violations to saturate the narrow counter.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 3'b001, 1'b0);
         idle(5);
      end
      // Reset mid-HOLD.
      step(1'b0, 3'b110, 1'b0);
      idle(2);
      step(1'b1, 3'b000, 1'b0);
      idle(6);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         bit         r;
         logic [2:0] s;
         bit         c;
         r = ($urandom_range(0, 199) == 0);
         s = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         c = ($urandom_range(0, 7) == 0);
         step(r, s, c);
      end
      idle(2);
      @(posedge clk);
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
